// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter.
// Requester IDs, parameter defaults and small helpers.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF    = 32;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_WORDS_DEF = 257;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

    function automatic req_id_e other(input req_id_e id);
        return (id == REQ_CPU) ? REQ_DBG : REQ_CPU;
    endfunction

    function automatic logic [1:0] onehot(input req_id_e id);
        return (id == REQ_DBG) ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick with a lock override.
// Purely combinational; all arbitration state lives in the caller.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  req_id_e    rr_ptr,
    input  req_id_e    owner,
    input  logic       lock_ok,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (lock_ok) begin
            grant = onehot(owner);
        end else begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = onehot(rr_ptr);
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the CPU MEM stage (m0)
// and the debug/DMA loader (m1), with a 1-cycle registered response.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MEM_WORDS = MEM_WORDS_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_write,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [DATA_W-1:0] m0_req_wdata,
    input  logic              m0_req_lock,
    output logic              m0_rsp_valid,
    output logic [DATA_W-1:0] m0_rsp_rdata,
    output logic              m0_rsp_err,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_write,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [DATA_W-1:0] m1_req_wdata,
    input  logic              m1_req_lock,
    output logic              m1_rsp_valid,
    output logic [DATA_W-1:0] m1_rsp_rdata,
    output logic              m1_rsp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [ADDR_W:0]  LIMIT     = (ADDR_W + 1)'(MEM_WORDS);

    req_id_e           rr_ptr;
    req_id_e           owner;
    logic              owner_vld;
    logic [CNT_W-1:0]  burst_cnt;

    logic [1:0]        valid;
    logic [1:0]        grant_raw;
    logic [1:0]        grant;
    logic              lock_ok;
    logic              hs;
    req_id_e           gid;

    logic              sel_write;
    logic              sel_lock;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              in_range;
    logic [DATA_W-1:0] rd_next;

    assign valid   = {m1_req_valid, m0_req_valid};
    assign lock_ok = owner_vld && valid[owner] && (burst_cnt < BURST_MAX);

    rr_arb2 u_arb (
        .valid   (valid),
        .rr_ptr  (rr_ptr),
        .owner   (owner),
        .lock_ok (lock_ok),
        .grant   (grant_raw)
    );

    // Reset masks the grant so nothing reaches memory in a reset cycle.
    assign grant = reset ? 2'b00 : grant_raw;
    assign hs    = |grant;
    assign gid   = grant[1] ? REQ_DBG : REQ_CPU;

    assign m0_req_ready = grant[0];
    assign m1_req_ready = grant[1];

    assign sel_write = grant[1] ? m1_req_write : m0_req_write;
    assign sel_lock  = grant[1] ? m1_req_lock  : m0_req_lock;
    assign sel_addr  = grant[1] ? m1_req_addr  : m0_req_addr;
    assign sel_wdata = grant[1] ? m1_req_wdata : m0_req_wdata;
    assign in_range  = {1'b0, sel_addr} < LIMIT;
    assign rd_next   = in_range ? mem_read_data : '0;

    always_comb begin
        mem_address    = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (hs) begin
            mem_address    = sel_addr;
            mem_write_data = sel_wdata;
            mem_write      = sel_write & in_range;
            mem_read       = ~sel_write;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr    <= REQ_CPU;
            owner     <= REQ_CPU;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end else if (hs) begin
            rr_ptr <= other(gid);
            if (sel_lock) begin
                owner     <= gid;
                owner_vld <= 1'b1;
                if (owner_vld && owner == gid) begin
                    // Saturate: an exhausted owner stays exhausted.
                    if (burst_cnt != BURST_MAX) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end else begin
                    burst_cnt <= CNT_W'(1);
                end
            end else begin
                owner_vld <= 1'b0;
                burst_cnt <= '0;
            end
        end else if (owner_vld && !valid[owner]) begin
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_rsp_valid <= 1'b0;
            m0_rsp_err   <= 1'b0;
            m0_rsp_rdata <= '0;
            m1_rsp_valid <= 1'b0;
            m1_rsp_err   <= 1'b0;
            m1_rsp_rdata <= '0;
        end else begin
            m0_rsp_valid <= grant[0];
            m0_rsp_err   <= grant[0] & ~in_range;
            m1_rsp_valid <= grant[1];
            m1_rsp_err   <= grant[1] & ~in_range;
            if (grant[0]) begin
                m0_rsp_rdata <= rd_next;
            end
            if (grant[1]) begin
                m1_rsp_rdata <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural memory and
// a transaction-level reference model checked every cycle.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NW = 257;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_init;
    logic          m0_req_valid, m0_req_ready, m0_req_write, m0_req_lock;
    logic [AW-1:0] m0_req_addr;
    logic [DW-1:0] m0_req_wdata, m0_rsp_rdata;
    logic          m0_rsp_valid, m0_rsp_err;
    logic          m1_req_valid, m1_req_ready, m1_req_write, m1_req_lock;
    logic [AW-1:0] m1_req_addr;
    logic [DW-1:0] m1_req_wdata, m1_rsp_rdata;
    logic          m1_rsp_valid, m1_rsp_err;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write, mem_read;

    logic [DW-1:0] mem     [0:NW-1];
    logic [DW-1:0] ref_mem [0:NW-1];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .m0_req_valid   (m0_req_valid),
        .m0_req_ready   (m0_req_ready),
        .m0_req_write   (m0_req_write),
        .m0_req_addr    (m0_req_addr),
        .m0_req_wdata   (m0_req_wdata),
        .m0_req_lock    (m0_req_lock),
        .m0_rsp_valid   (m0_rsp_valid),
        .m0_rsp_rdata   (m0_rsp_rdata),
        .m0_rsp_err     (m0_rsp_err),
        .m1_req_valid   (m1_req_valid),
        .m1_req_ready   (m1_req_ready),
        .m1_req_write   (m1_req_write),
        .m1_req_addr    (m1_req_addr),
        .m1_req_wdata   (m1_req_wdata),
        .m1_req_lock    (m1_req_lock),
        .m1_rsp_valid   (m1_rsp_valid),
        .m1_rsp_rdata   (m1_rsp_rdata),
        .m1_rsp_err     (m1_rsp_err),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    // Stand-in for data_memory: preload, sync write, comb read with forwarding.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < NW; i++) mem[i] <= 32'h1000_0000 | i;
        end else if (mem_write && mem_address < NW) begin
            mem[mem_address[8:0]] <= mem_write_data;
        end
    end

    always_comb begin
        mem_read_data = '0;
        if (mem_write) mem_read_data = mem_write_data;
        else if (mem_address < NW) mem_read_data = mem[mem_address[8:0]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who must win, what memory must see, what comes back.
    initial begin : model
        int  prefer, own, streak, g;
        bit  own_v, known;
        bit  ev [2];
        bit  ee [2];
        logic [31:0] ed [2];
        logic v [2], w [2], l [2];
        logic [31:0] a [2], d [2];
        bit inr;
        prefer = 0; own = 0; streak = 0; own_v = 0; known = 0;
        ev = '{0, 0}; ee = '{0, 0}; ed = '{0, 0};
        for (int i = 0; i < NW; i++) ref_mem[i] = 32'h1000_0000 | i;
        forever begin
            @(negedge clk);
            if (known) begin
                chk1("m0_rsp_valid", m0_rsp_valid, ev[0]);
                chk1("m1_rsp_valid", m1_rsp_valid, ev[1]);
                chk1("m0_rsp_err", m0_rsp_err, ee[0]);
                chk1("m1_rsp_err", m1_rsp_err, ee[1]);
                if (ev[0]) chk("m0_rsp_rdata", m0_rsp_rdata, ed[0]);
                if (ev[1]) chk("m1_rsp_rdata", m1_rsp_rdata, ed[1]);
            end
            v = '{m0_req_valid, m1_req_valid};
            w = '{m0_req_write, m1_req_write};
            l = '{m0_req_lock, m1_req_lock};
            a = '{m0_req_addr, m1_req_addr};
            d = '{m0_req_wdata, m1_req_wdata};
            ev = '{0, 0}; ee = '{0, 0};
            g = -1;
            if (reset) begin
                prefer = 0; own_v = 0; streak = 0; known = 1;
            end else begin
                if (own_v && v[own] && streak < MB) g = own;
                else if (v[0] && v[1]) g = prefer;
                else if (v[0]) g = 0;
                else if (v[1]) g = 1;
            end
            chk1("m0_req_ready", m0_req_ready, g == 0);
            chk1("m1_req_ready", m1_req_ready, g == 1);
            if (g < 0) begin
                chk("mem_address", mem_address, 0);
                chk("mem_write_data", mem_write_data, 0);
                chk1("mem_write", mem_write, 1'b0);
                chk1("mem_read", mem_read, 1'b0);
                if (!reset) begin own_v = 0; streak = 0; end
            end else begin
                inr = a[g] < NW;
                chk("mem_address", mem_address, a[g]);
                chk("mem_write_data", mem_write_data, d[g]);
                chk1("mem_write", mem_write, w[g] && inr);
                chk1("mem_read", mem_read, !w[g]);
                ev[g] = 1;
                ee[g] = !inr;
                ed[g] = !inr ? 32'h0 : (w[g] ? d[g] : ref_mem[a[g]]);
                if (w[g] && inr) ref_mem[a[g]] = d[g];
                prefer = 1 - g;
                if (l[g]) begin
                    streak = (own_v && own == g) ? ((streak < MB) ? streak + 1 : MB) : 1;
                    own = g;
                    own_v = 1;
                end else begin
                    own_v = 0;
                    streak = 0;
                end
            end
        end
    end

    task automatic set_m0(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        m0_req_valid = v; m0_req_write = w; m0_req_addr = a;
        m0_req_wdata = d; m0_req_lock = l;
    endtask

    task automatic set_m1(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic l);
        m1_req_valid = v; m1_req_write = w; m1_req_addr = a;
        m1_req_wdata = d; m1_req_lock = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        reset = 1'b1;
        mem_init = 1'b1;
        set_m0(1, 1, 3, 32'hBAD0_BAD0, 0);
        set_m1(1, 1, 4, 32'hBAD1_BAD1, 0);
        tick();
        mem_init = 1'b0;
        @(negedge clk);
        chk1("rst_m0_ready", m0_req_ready, 1'b0);
        chk1("rst_m1_ready", m1_req_ready, 1'b0);
        chk1("rst_mem_write", mem_write, 1'b0);
        tick();
        reset = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("rst_m0_rsp", m0_rsp_valid, 1'b0);
        chk1("rst_m1_rsp", m1_rsp_valid, 1'b0);
        chk("rst_mem3", mem[3], 32'h1000_0003);
        chk("rst_mem4", mem[4], 32'h1000_0004);

        tick();
        set_m0(1, 0, 5, 0, 0);
        @(negedge clk);
        chk1("ld5_ready", m0_req_ready, 1'b1);
        chk("ld5_addr", mem_address, 5);
        tick();
        set_m0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("ld5_rsp_valid", m0_rsp_valid, 1'b1);
        chk("ld5_rdata", m0_rsp_rdata, 32'h1000_0005);

        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_m0(1, 0, 6, 0, 0);
        set_m1(1, 0, 7, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("rr_m0", m0_req_ready, (i % 2) == 0);
            chk1("rr_m1", m1_req_ready, (i % 2) == 1);
            tick();
        end

        set_m0(0, 0, 0, 0, 0);
        set_m1(1, 1, 8, 32'hDEAD_BEEF, 0);
        tick();
        set_m1(0, 0, 0, 0, 0);
        set_m0(1, 0, 8, 0, 0);
        tick();
        set_m0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("raw_rsp_valid", m0_rsp_valid, 1'b1);
        chk("raw_rdata", m0_rsp_rdata, 32'hDEAD_BEEF);

        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_m0(1, 0, 10, 0, 1);
        set_m1(1, 0, 20, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1("burst_m0", m0_req_ready, i != 4);
            chk1("burst_m1", m1_req_ready, i == 4);
            tick();
            set_m0(1, 0, 11 + i, 0, 1);
        end
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);

        tick();
        set_m0(1, 1, 32'h101, 32'h55AA_55AA, 0);
        @(negedge clk);
        chk1("oor_ready", m0_req_ready, 1'b1);
        chk1("oor_mem_write", mem_write, 1'b0);
        tick();
        set_m0(1, 0, 32'h100, 0, 0);
        @(negedge clk);
        chk1("oor_rsp_valid", m0_rsp_valid, 1'b1);
        chk1("oor_err", m0_rsp_err, 1'b1);
        chk("oor_rdata", m0_rsp_rdata, 0);
        chk("oor_mem100", mem[256], 32'h1000_0100);
        tick();
        set_m0(0, 0, 0, 0, 0);
        @(negedge clk);
        chk1("top_err", m0_rsp_err, 1'b0);
        chk("top_rdata", m0_rsp_rdata, 32'h1000_0100);

        // m1 locks, drops valid mid-burst, then contends again.
        tick();
        set_m1(1, 1, 30, 32'h0000_0030, 1);
        tick();
        set_m1(1, 0, 30, 0, 1);
        tick();
        set_m1(0, 0, 0, 0, 0);
        set_m0(1, 0, 31, 0, 0);
        tick();
        set_m0(1, 0, 32, 0, 1);
        set_m1(1, 0, 30, 0, 1);
        repeat (7) tick();
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
